// File: rtl/motor_pwm_ctrl.sv
// Two-bridge motor driver: dead-time sequenced direction changes, PWM speed control,
// overcurrent lockout with a fault-free hold-off, and 7-segment status digit codes.
module motor_pwm_ctrl #(
  parameter int unsigned PWM_PERIOD = 100000,
  parameter int unsigned DEADTIME   = 1000000,
  parameter int unsigned FAULT_HOLD = 100000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] sw_speed,
  input  logic [3:0] sw_dir,
  input  logic       sw_en,
  input  logic       comp_a,
  input  logic       comp_b,
  output logic       ena,
  output logic       enb,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  output logic       fault,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3
);

  localparam int unsigned CW  = $clog2(PWM_PERIOD);
  localparam int unsigned DW  = $clog2(PWM_PERIOD + 1);
  localparam int unsigned DTW = $clog2(DEADTIME + 1);
  localparam int unsigned FHW = $clog2(FAULT_HOLD + 1);
  localparam int unsigned SYW = 11;

  localparam logic [DW-1:0] DUTY_25  = DW'(PWM_PERIOD * 25 / 100);
  localparam logic [DW-1:0] DUTY_50  = DW'(PWM_PERIOD * 50 / 100);
  localparam logic [DW-1:0] DUTY_75  = DW'(PWM_PERIOD * 75 / 100);
  localparam logic [DW-1:0] DUTY_100 = DW'(PWM_PERIOD);

  typedef enum logic [1:0] {ST_STOP, ST_DEAD, ST_RUN, ST_FAULT} state_e;
  typedef enum logic [2:0] {DIR_STOP, DIR_FWD, DIR_BACK, DIR_LEFT, DIR_RIGHT} dir_e;

  logic [SYW-1:0] sync1_q, sync2_q;
  state_e         state_q, state_d;
  dir_e           dir_q, dir_d, dir_sel;
  logic [DW-1:0]  duty_q, duty_d, duty_sel;
  logic [CW-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [DTW-1:0] dead_cnt_q, dead_cnt_d;
  logic [FHW-1:0] fault_cnt_q, fault_cnt_d;
  logic           ena_q, ena_d;
  logic [3:0]     pins_q, pins_d;
  logic           fault_q, fault_d;
  logic [15:0]    disp_q, disp_d;

  logic [3:0]     speed_s, dir_s;
  logic           en_s, flt_s, go;
  logic [11:0]    duty_digits;
  logic [3:0]     dir_digit;

  // Two-flop synchronizers for every switch and comparator input
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_speed, sw_dir, sw_en, comp_a, comp_b};
      sync2_q <= sync1_q;
    end
  end

  // Switch decode: lowest speed bit wins, highest direction bit wins
  always_comb begin
    speed_s     = sync2_q[10:7];
    dir_s       = sync2_q[6:3];
    en_s        = sync2_q[2];
    flt_s       = sync2_q[1] | sync2_q[0];
    duty_sel    = '0;
    duty_digits = 12'hF00;
    if (speed_s[0]) begin
      duty_sel    = DUTY_25;
      duty_digits = 12'hF25;
    end else if (speed_s[1]) begin
      duty_sel    = DUTY_50;
      duty_digits = 12'hF50;
    end else if (speed_s[2]) begin
      duty_sel    = DUTY_75;
      duty_digits = 12'hF75;
    end else if (speed_s[3]) begin
      duty_sel    = DUTY_100;
      duty_digits = 12'h100;
    end
    dir_sel   = DIR_STOP;
    dir_digit = 4'd15;
    if (dir_s[3]) begin
      dir_sel   = DIR_RIGHT;
      dir_digit = 4'd13;
    end else if (dir_s[2]) begin
      dir_sel   = DIR_LEFT;
      dir_digit = 4'd12;
    end else if (dir_s[1]) begin
      dir_sel   = DIR_BACK;
      dir_digit = 4'd10;
    end else if (dir_s[0]) begin
      dir_sel   = DIR_FWD;
      dir_digit = 4'd11;
    end
    go = en_s && (dir_sel != DIR_STOP) && (duty_sel != '0);
  end

  // Next state; outputs are derived from next-state values so they register in step with state
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    duty_d      = duty_q;
    pwm_cnt_d   = pwm_cnt_q;
    dead_cnt_d  = dead_cnt_q;
    fault_cnt_d = fault_cnt_q;
    if (flt_s) begin
      state_d     = ST_FAULT;
      fault_cnt_d = '0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (go) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
          end
        end
        ST_DEAD: begin
          if (!go) begin
            state_d = ST_STOP;
          end else if (dead_cnt_q == DTW'(DEADTIME - 1)) begin
            state_d   = ST_RUN;
            dir_d     = dir_sel;
            duty_d    = duty_sel;
            pwm_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q + DTW'(1);
          end
        end
        ST_RUN: begin
          if (!go) begin
            state_d = ST_STOP;
          end else if (dir_sel != dir_q) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
          end else if (pwm_cnt_q == CW'(PWM_PERIOD - 1)) begin
            // New duty is only adopted at the period boundary
            pwm_cnt_d = '0;
            duty_d    = duty_sel;
          end else begin
            pwm_cnt_d = pwm_cnt_q + CW'(1);
          end
        end
        ST_FAULT: begin
          if (fault_cnt_q == FHW'(FAULT_HOLD - 1)) begin
            state_d     = ST_STOP;
            fault_cnt_d = '0;
          end else begin
            fault_cnt_d = fault_cnt_q + FHW'(1);
          end
        end
        default: state_d = ST_STOP;
      endcase
    end

    ena_d  = (state_d == ST_RUN) && (DW'(pwm_cnt_d) < duty_d);
    pins_d = '0;
    if (state_d == ST_RUN) begin
      case (dir_d)
        DIR_FWD:   pins_d = 4'b1010;
        DIR_BACK:  pins_d = 4'b0101;
        DIR_LEFT:  pins_d = 4'b0110;
        DIR_RIGHT: pins_d = 4'b1001;
        default:   pins_d = 4'b0000;
      endcase
    end
    fault_d = (state_d == ST_FAULT);
    disp_d  = (state_d == ST_FAULT) ? 16'hBBBB : {duty_digits, dir_digit};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_STOP;
      dir_q       <= DIR_STOP;
      duty_q      <= '0;
      pwm_cnt_q   <= '0;
      dead_cnt_q  <= '0;
      fault_cnt_q <= '0;
      ena_q       <= 1'b0;
      pins_q      <= '0;
      fault_q     <= 1'b0;
      disp_q      <= 16'hFFFF;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      pwm_cnt_q   <= pwm_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      ena_q       <= ena_d;
      pins_q      <= pins_d;
      fault_q     <= fault_d;
      disp_q      <= disp_d;
    end
  end

  assign ena   = ena_q;
  assign enb   = ena_q;
  assign in1   = pins_q[3];
  assign in2   = pins_q[2];
  assign in3   = pins_q[1];
  assign in4   = pins_q[0];
  assign fault = fault_q;
  assign disp0 = disp_q[3:0];
  assign disp1 = disp_q[7:4];
  assign disp2 = disp_q[11:8];
  assign disp3 = disp_q[15:12];

endmodule

// File: doc/motor_pwm_ctrl.md
MOTOR_PWM_CTRL -- requirements
Module: motor_pwm_ctrl

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 100000, meaning PWM period in clock cycles; must be a multiple of 4.
REQ-002 SHALL have parameter DEADTIME, default 1000000, meaning the cycles both bridges are held off before driving or reversing.
REQ-003 SHALL have parameter FAULT_HOLD, default 100000000, meaning the consecutive fault-free cycles required to leave FAULT.
REQ-004 clock  input  1  system clock; all logic on its rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 sw_speed  input  4  speed select: [0]=25%, [1]=50%, [2]=75%, [3]=100%; lowest set bit wins; none set = 0%.
REQ-007 sw_dir  input  4  direction: [0]=fwd, [1]=back, [2]=left, [3]=right; highest set bit wins; none set = stop.
REQ-008 sw_en  input  1  drive enable switch.
REQ-009 comp_a, comp_b  input  1 each  asynchronous overcurrent comparator outputs for motors A and B, active-high.
REQ-010 ena, enb  output  1 each  PWM enables for bridge A and bridge B.
REQ-011 in1, in2, in3, in4  output  1 each  bridge direction pins: in1/in2 for motor A, in3/in4 for motor B.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 disp0..disp3  output  4 each  digit codes for the 7-segment stage: 0-9 = digit, 10 = b, 11 = F, 12 = L, 13 = R, 15 = dash.

Function
REQ-014 SHALL pass sw_speed, sw_dir, sw_en, comp_a and comp_b each through a 2-flop synchronizer; all logic below uses the synchronized values.
REQ-015 SHALL implement states STOP, DEAD, RUN and FAULT, with all outputs registered.
REQ-016 STOP SHALL hold ena=enb=0 and in1..in4=0.
REQ-016a STOP SHALL go to DEAD when sw_en=1, direction is not stop and duty is not 0%.
REQ-017 DEAD SHALL hold ena=enb=0 and in1..in4=0 for exactly DEADTIME cycles, latch the current direction and duty, then go to RUN.
REQ-018 RUN SHALL drive direction pins as follows: fwd in1..in4=1010, back 0101, left 0110, right 1001.
REQ-019 RUN SHALL go to DEAD when the synchronized direction differs from the latched direction; ena and enb go low on the next cycle.
REQ-020 RUN SHALL go to STOP when sw_en=0, direction is stop, or duty is 0%.
REQ-021 The PWM counter SHALL be $clog2(PWM_PERIOD) bits wide, cleared on entry to RUN, and count 0..PWM_PERIOD-1 then wrap to 0.
REQ-022 ena and enb SHALL equal (pwm_cnt < duty_cycles), where duty_cycles = PWM_PERIOD*pct/100 and is computed as a constant per selection.
REQ-022a At 100% duty, ena and enb SHALL stay constant high with no glitch at wrap.
REQ-023 In RUN, a duty change SHALL take effect only when pwm_cnt wraps from PWM_PERIOD-1 to 0, with no dead time.
REQ-024 Synchronized comp_a or comp_b high SHALL force FAULT from any state on the next cycle.
REQ-024a In FAULT, ena, enb and in1..in4 SHALL all be 0, and fault SHALL be 1.
REQ-025 FAULT SHALL count consecutive cycles with both comparators low; any comparator high SHALL clear the count.
REQ-025a When the count reaches FAULT_HOLD, FAULT SHALL go to STOP; leaving STOP requires the REQ-016a conditions again.
REQ-026 Simultaneous fault and command change SHALL resolve with fault taking priority.
REQ-026a Simultaneous direction change and PWM wrap SHALL resolve by going to DEAD; the duty update is discarded.
REQ-027 disp0 SHALL show the direction as fwd 11, back 10, left 12, right 13, stop 15.
REQ-028 disp3..disp1 SHALL show the selected duty as 25% = 15,2,5; 50% = 15,5,0; 75% = 15,7,5; 100% = 1,0,0; 0% = 15,0,0.
REQ-028a disp outputs SHALL reflect synchronized switches in every state except FAULT.
REQ-029 In FAULT, disp0..disp3 SHALL all be 11.
REQ-030 Raw comparator assertion to bridge-off latency SHALL be at most 3 cycles.

Reset
REQ-031 While resetn=0 at a clock edge, state SHALL become STOP and all counters and synchronizers SHALL clear.
REQ-031a While resetn=0 at a clock edge, ena, enb, in1..in4 and fault SHALL be 0, and disp0..disp3 SHALL be 15.
REQ-032 Reset asserted mid-DEAD, mid-RUN or mid-FAULT SHALL take effect at the next edge, with no residual PWM or fault.

Verification (PWM_PERIOD=20, DEADTIME=5, FAULT_HOLD=10)
REQ-033 Reset check: resetn low 3 cycles -> all drive outputs 0, fault=0, disp0..disp3=15.
REQ-034 Forward drive: sw_en=1, sw_dir=0001, sw_speed=0010 -> DEAD 5 cycles with ena=0; then in1..in4=1010, ena/enb high 10 of every 20 cycles; disp=11,0,5,15 (disp0..disp3).
REQ-035 Reversal: in RUN, sw_dir 0001->0010 -> ena=0 within 3 cycles; 5 dead cycles; then in1..in4=0101, disp0=10.
REQ-036 Duty change: sw_speed 0010->0100 at pwm_cnt=3 -> current period keeps 10 high cycles; next period has 15 high cycles; no dead time.
REQ-037 Fault: 1-cycle comp_a pulse in RUN -> within 3 cycles all drive outputs 0, fault=1, disp all 11.
REQ-037a Fault recovery: comp_b pulse 4 cycles into hold restarts the count; exit to STOP 10 cycles after the last pulse; then DEAD->RUN since the command is still present.
REQ-038 Reset during FAULT: resetn low -> STOP and fault=0 at the next edge; 100% duty gives ena constant 1 across wraps.
